// File: rtl/local_input_buffer.sv
// Router local-port input buffer: injector req/grant/full handshake in,
// DEPTH-entry FIFO, head packet offered to the switch arbiter.
module local_input_buffer #(
  parameter int dataWidth = 32,
  parameter int DEPTH     = 4,
  parameter int ADDR      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ReqUpStr,
  input  logic [dataWidth-1:0] PacketIn,
  output logic                 GntUpStr,
  output logic                 UpStrFull,
  output logic                 ReqDnStr,
  output logic [dataWidth-1:0] PacketOut,
  input  logic                 GntDnStr,
  output logic [ADDR:0]        UsedWords
);

  localparam logic [ADDR-1:0] PTR_ONE  = 1;
  localparam logic [ADDR:0]   CNT_ONE  = 1;
  localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);

  logic [dataWidth-1:0] mem_q [DEPTH];
  logic [ADDR-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]        count_q, count_d;
  logic                 gnt_q, gnt_d;
  logic                 full_q, full_d;
  logic                 push, pop;

  // Grant term stops a second write while the injector still holds req.
  assign push = ReqUpStr && !gnt_q && !full_q;
  assign pop  = GntDnStr && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    gnt_d    = push;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      gnt_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      gnt_q    <= gnt_d;
      full_q   <= full_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= PacketIn;
  end

  assign GntUpStr  = gnt_q;
  assign UpStrFull = full_q;
  assign ReqDnStr  = (count_q != '0);
  assign PacketOut = ReqDnStr ? mem_q[rd_ptr_q] : '0;
  assign UsedWords = count_q;

endmodule
